mux_scan_sequencer: RTL and testbench

Sequential select generator that drives the `s1`/`s0` select pair of the 4:1 mux. It steps through the four mux inputs in ascending order, skips masked channels, and holds each selection for a programmable dwell time. It signals completion of each full scan. It sits directly upstream of the 4:1 mux and also consumes the mux output `y`, so a full scan can capture a 4-bit snapshot of the mux inputs.

---
 rtl/mux_scan_sequencer_pkg.sv | 10 +
 rtl/mux_scan_sequencer_if.sv | 28 ++
 rtl/mux_scan_sequencer_mask_next_channel.sv | 22 ++
 rtl/mux_scan_sequencer.sv | 134 +++++++++++++
 tb/tb_mux_scan_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: channel geometry and FSM state encoding.
package mux_scan_sequencer_pkg;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;
endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Control/select bundle between a scan controller (master) and the sequencer (slave).
interface mux_scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    import mux_scan_sequencer_pkg::*;

    logic               start;
    logic               abort;
    logic               continuous;
    logic [N_CH-1:0]    mask;
    logic [DWELL_W-1:0] dwell;
    logic               y;
    logic               s0;
    logic               s1;
    logic               busy;
    logic               done;
    logic [N_CH-1:0]    sample;

    modport master (
        output start, abort, continuous, mask, dwell, y,
        input  s0, s1, busy, done, sample
    );

    modport slave (
        input  start, abort, continuous, mask, dwell, y,
        output s0, s1, busy, done, sample
    );
endinterface

// File: rtl/mux_scan_sequencer_mask_next_channel.sv
// Finds the next higher enabled channel after i_cur, or the lowest enabled one when i_wrap is set.
module mask_next_channel
    import mux_scan_sequencer_pkg::*;
(
    input  logic [N_CH-1:0]  i_mask,
    input  logic [SEL_W-1:0] i_cur,
    input  logic             i_wrap,
    output logic [SEL_W-1:0] o_next,
    output logic             o_none
);
    // Descending walk so the last hit is the lowest qualifying channel.
    always_comb begin
        o_next = i_cur;
        o_none = 1'b1;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_wrap || (i > int'(i_cur)))) begin
                o_next = SEL_W'(i);
                o_none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer driving the 4:1 mux selects; define SCAN_CAPTURE_EN to build the y snapshot register.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int DWELL_W = 8
)
(
    input  logic                 clk,
    input  logic                 rst,
    mux_scan_sequencer_if.slave  bus
);
    state_t             r_state, w_state;
    logic [SEL_W-1:0]   r_sel, w_sel;
    logic [DWELL_W-1:0] r_cnt, w_cnt;
    logic [DWELL_W-1:0] r_dwell, w_dwell;
    logic [N_CH-1:0]    r_mask, w_mask;
    logic               r_done, w_done;
    logic               w_capture;
    logic [SEL_W-1:0]   w_next_sel, w_first_sel;
    logic               w_next_none, w_first_none;

    function automatic logic [DWELL_W-1:0] dwell_floor(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    // Advance within the latched mask; the second lookup serves start and wrap from the live mask.
    mask_next_channel u_next (
        .i_mask (r_mask),
        .i_cur  (r_sel),
        .i_wrap (1'b0),
        .o_next (w_next_sel),
        .o_none (w_next_none)
    );

    mask_next_channel u_first (
        .i_mask (bus.mask),
        .i_cur  (r_sel),
        .i_wrap (1'b1),
        .o_next (w_first_sel),
        .o_none (w_first_none)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_mask  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_sel   <= w_sel;
            r_cnt   <= w_cnt;
            r_dwell <= w_dwell;
            r_mask  <= w_mask;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_sel     = r_sel;
        w_cnt     = r_cnt;
        w_dwell   = r_dwell;
        w_mask    = r_mask;
        w_done    = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (w_first_none) begin
                        w_done = 1'b1;
                    end else begin
                        w_mask  = bus.mask;
                        w_dwell = bus.dwell;
                        w_sel   = w_first_sel;
                        w_cnt   = dwell_floor(bus.dwell);
                        w_state = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (bus.abort) begin
                    w_state = ST_IDLE;
                    w_cnt   = '0;
                end else if (r_cnt > DWELL_W'(1)) begin
                    w_cnt = r_cnt - DWELL_W'(1);
                end else begin
                    w_capture = 1'b1;
                    if (!w_next_none) begin
                        w_sel = w_next_sel;
                        w_cnt = dwell_floor(r_dwell);
                    end else begin
                        w_done = 1'b1;
                        if (bus.continuous && !w_first_none) begin
                            w_mask  = bus.mask;
                            w_dwell = bus.dwell;
                            w_sel   = w_first_sel;
                            w_cnt   = dwell_floor(bus.dwell);
                        end else begin
                            w_state = ST_IDLE;
                            w_cnt   = '0;
                        end
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

`ifdef SCAN_CAPTURE_EN
    logic [N_CH-1:0] r_sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= '0;
        end else if (w_capture) begin
            r_sample[r_sel] <= bus.y;
        end
    end

    assign bus.sample = r_sample;
`else
    logic w_unused_capture;
    assign w_unused_capture = bus.y ^ w_capture;
    assign bus.sample       = '0;
`endif

    assign bus.s1   = r_sel[1];
    assign bus.s0   = r_sel[0];
    assign bus.busy = (r_state == ST_SCAN);
    assign bus.done = r_done;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: expected per-cycle select/busy/done queued at drive time.
module tb_mux_scan_sequencer;
    import mux_scan_sequencer_pkg::*;

    localparam int DWELL_W = 8;

`ifdef SCAN_CAPTURE_EN
    localparam logic [3:0] CAP_EXP = 4'b1010;
`else
    localparam logic [3:0] CAP_EXP = 4'b0000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] mux_in;

    always #5 clk = ~clk;

    mux_scan_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    assign bus.y = mux_in[{bus.s1, bus.s0}];

    mux_scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic       chk_s;
        logic [3:0] smp;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] last_sel = 2'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic exp_push(input logic [1:0] sel, input logic busy, input logic done,
                            input logic chk_s, input logic [3:0] smp);
        exp_t e;
        e.sel   = sel;
        e.busy  = busy;
        e.done  = done;
        e.chk_s = chk_s;
        e.smp   = smp;
        sb.push_back(e);
        last_sel = sel;
    endtask

    // Non-continuous scan: each enabled channel for max(dwell,1) cycles, done cycle, one idle cycle.
    task automatic push_scan(input logic [3:0] mask, input int dwell,
                             input logic chk_s, input logic [3:0] smp);
        int d;
        d = (dwell == 0) ? 1 : dwell;
        for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) begin
                for (int k = 0; k < d; k++) exp_push(2'(ch), 1'b1, 1'b0, 1'b0, 4'b0);
            end
        end
        exp_push(last_sel, 1'b0, 1'b1, chk_s, smp);
        exp_push(last_sel, 1'b0, 1'b0, 1'b0, 4'b0);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_underrun"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_sel"},  32'({bus.s1, bus.s0}), 32'(e.sel));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(e.busy));
        chk({tag, "_done"}, 32'(bus.done), 32'(e.done));
        if (e.chk_s) chk({tag, "_sample"}, 32'(bus.sample), 32'(e.smp));
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) step(tag);
    endtask

    task automatic start_scan(input logic [3:0] mask, input int dwell, input logic cont);
        bus.mask       = mask;
        bus.dwell      = DWELL_W'(dwell);
        bus.continuous = cont;
        bus.start      = 1'b1;
    endtask

    initial begin
        rst            = 1'b1;
        mux_in         = 4'b0000;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.continuous = 1'b0;
        bus.mask       = 4'b0000;
        bus.dwell      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sel",    32'({bus.s1, bus.s0}), 32'd0);
        chk("reset_busy",   32'(bus.busy), 32'd0);
        chk("reset_done",   32'(bus.done), 32'd0);
        chk("reset_sample", 32'(bus.sample), 32'd0);
        rst = 1'b0;

        // Full scan, dwell 3
        start_scan(4'b1111, 3, 1'b0);
        push_scan(4'b1111, 3, 1'b0, 4'b0);
        step("full");
        bus.start = 1'b0;
        drain("full");

        // Sparse mask with zero dwell, then empty mask
        start_scan(4'b1010, 0, 1'b0);
        push_scan(4'b1010, 0, 1'b0, 4'b0);
        step("sparse");
        bus.start = 1'b0;
        drain("sparse");
        start_scan(4'b0000, 2, 1'b0);
        exp_push(last_sel, 1'b0, 1'b1, 1'b0, 4'b0);
        exp_push(last_sel, 1'b0, 1'b0, 1'b0, 4'b0);
        step("empty");
        bus.start = 1'b0;
        drain("empty");

        // Continuous: mask change mid-scan takes effect on wrap, then abort mid-dwell
        start_scan(4'b0011, 2, 1'b1);
        exp_push(2'd0, 1'b1, 1'b0, 1'b0, 4'b0);
        exp_push(2'd0, 1'b1, 1'b0, 1'b0, 4'b0);
        exp_push(2'd1, 1'b1, 1'b0, 1'b0, 4'b0);
        exp_push(2'd1, 1'b1, 1'b0, 1'b0, 4'b0);
        exp_push(2'd3, 1'b1, 1'b1, 1'b0, 4'b0);
        exp_push(2'd3, 1'b1, 1'b0, 1'b0, 4'b0);
        exp_push(2'd3, 1'b1, 1'b1, 1'b0, 4'b0);
        step("cont");
        bus.start = 1'b0;
        bus.mask  = 4'b1000;
        drain("cont");
        bus.abort      = 1'b1;
        bus.continuous = 1'b0;
        exp_push(2'd3, 1'b0, 1'b0, 1'b0, 4'b0);
        step("cont_abort");
        bus.abort = 1'b0;
        exp_push(2'd3, 1'b0, 1'b0, 1'b0, 4'b0);
        drain("cont_idle");

        // Abort coinciding with the end of the last dwell: no done
        start_scan(4'b0001, 1, 1'b0);
        exp_push(2'd0, 1'b1, 1'b0, 1'b0, 4'b0);
        step("abort_end");
        bus.start = 1'b0;
        bus.abort = 1'b1;
        exp_push(2'd0, 1'b0, 1'b0, 1'b0, 4'b0);
        step("abort_end");
        bus.abort = 1'b0;
        exp_push(2'd0, 1'b0, 1'b0, 1'b0, 4'b0);
        drain("abort_end");

        // Start re-asserted while busy with a different mask is ignored
        start_scan(4'b1111, 1, 1'b0);
        push_scan(4'b1111, 1, 1'b0, 4'b0);
        step("busy_start");
        bus.mask = 4'b0001;
        step("busy_start");
        bus.start = 1'b0;
        drain("busy_start");

        // Maximum dwell on a single channel
        start_scan(4'b0100, 255, 1'b0);
        push_scan(4'b0100, 255, 1'b0, 4'b0);
        step("max_dwell");
        bus.start = 1'b0;
        drain("max_dwell");

        // Capture of mux inputs a=0 b=1 c=0 d=1
        mux_in = 4'b1010;
        start_scan(4'b1111, 2, 1'b0);
        push_scan(4'b1111, 2, 1'b1, CAP_EXP);
        step("capture");
        bus.start = 1'b0;
        drain("capture");

        // Reset mid-scan forces all reset values at once
        start_scan(4'b1111, 3, 1'b0);
        push_scan(4'b1111, 3, 1'b0, 4'b0);
        step("pre_rst");
        bus.start = 1'b0;
        repeat (4) step("pre_rst");
        sb.delete();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_sel",    32'({bus.s1, bus.s0}), 32'd0);
        chk("midrst_busy",   32'(bus.busy), 32'd0);
        chk("midrst_done",   32'(bus.done), 32'd0);
        chk("midrst_sample", 32'(bus.sample), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_sel = 2'd0;
        repeat (3) exp_push(2'd0, 1'b0, 1'b0, 1'b1, 4'b0);
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
